// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true LRU.
// On halt every dirty block is written back, then the hit count, then flushed rises.
module dcache_nway #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int AW = $clog2(WAYS);
  localparam int TW = 30 - OB - IB;
  localparam int OW = (OB == 0) ? 1 : OB;
  localparam int SW = IB + AW;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_COUNT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [TW-1:0]     r_tag   [SETS][WAYS];
  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [AW-1:0]     r_age   [SETS][WAYS];
  logic [31:0]       r_data  [SETS][WAYS][WORDS];
  logic [OW-1:0]     r_wcnt;
  logic [AW-1:0]     r_vway;
  logic [IB-1:0]     r_midx;
  logic [TW-1:0]     r_mtag;
  logic [SW-1:0]     r_scan;
  logic [31:0]       r_hits;

  logic [IB-1:0]     w_idx, w_sidx;
  logic [TW-1:0]     w_tag;
  logic [OW-1:0]     w_woff, w_wnext;
  logic [AW-1:0]     w_hway, w_vway, w_sway;
  logic              w_hit, w_vfound, w_req, w_last, w_slast, w_sdirty;

  assign w_req    = dmemREN | dmemWEN;
  assign w_idx    = dmemaddr[2+OB +: IB];
  assign w_tag    = dmemaddr[31 -: TW];
  assign w_woff   = OW'((dmemaddr >> 2) & 32'(WORDS - 1));
  assign w_last   = (r_wcnt == OW'(WORDS - 1));
  assign w_wnext  = w_last ? '0 : r_wcnt + 1'b1;
  assign w_sidx   = r_scan[AW +: IB];
  assign w_sway   = r_scan[AW-1:0];
  assign w_slast  = (r_scan == SW'(SETS * WAYS - 1));
  assign w_sdirty = r_valid[w_sidx][w_sway] & r_dirty[w_sidx][w_sway];

  function automatic logic [31:0] baddr(input logic [TW-1:0] t, input logic [IB-1:0] i,
                                        input logic [OW-1:0] w);
    baddr = (32'({t, i}) << (2 + OB)) | (32'(w) << 2);
  endfunction

  // Hit way, then victim: lowest invalid way, else the oldest (age WAYS-1).
  always_comb begin
    w_hit    = 1'b0;
    w_hway   = '0;
    w_vfound = 1'b0;
    w_vway   = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = AW'(w);
      end
    for (int w = 0; w < WAYS; w++)
      if (!w_vfound && !r_valid[w_idx][w]) begin
        w_vfound = 1'b1;
        w_vway   = AW'(w);
      end
    if (!w_vfound)
      for (int w = 0; w < WAYS; w++)
        if (r_age[w_idx][w] == AW'(WAYS - 1)) w_vway = AW'(w);
  end

  always_comb begin
    w_next   = r_state;
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    flushed  = 1'b0;
    case (r_state)
      S_IDLE:
        if (halt) w_next = S_FLUSH;
        else if (w_req) begin
          if (w_hit) begin
            dhit     = 1'b1;
            dmemload = r_data[w_idx][w_hway][w_woff];
          end else
            w_next = (r_valid[w_idx][w_vway] && r_dirty[w_idx][w_vway]) ? S_WB : S_FILL;
        end
      S_WB: begin
        dWEN   = 1'b1;
        daddr  = baddr(r_tag[r_midx][r_vway], r_midx, r_wcnt);
        dstore = r_data[r_midx][r_vway][r_wcnt];
        if (!dwait && w_last) w_next = S_FILL;
      end
      S_FILL: begin
        dREN  = 1'b1;
        daddr = baddr(r_mtag, r_midx, r_wcnt);
        if (!dwait && w_last) w_next = S_IDLE;
      end
      S_FLUSH:
        if (w_sdirty) begin
          dWEN   = 1'b1;
          daddr  = baddr(r_tag[w_sidx][w_sway], w_sidx, r_wcnt);
          dstore = r_data[w_sidx][w_sway][r_wcnt];
          if (!dwait && w_last && w_slast) w_next = S_COUNT;
        end else if (w_slast) w_next = S_COUNT;
      S_COUNT: begin
        dWEN   = 1'b1;
        daddr  = 32'h3100 + 32'(4 * CPUID);
        dstore = r_hits;
        if (!dwait) w_next = S_DONE;
      end
      S_DONE:  flushed = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_vway  <= '0;
      r_midx  <= '0;
      r_mtag  <= '0;
      r_scan  <= '0;
      r_hits  <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= AW'(w);
        end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:
          if (halt) begin
            r_scan <= '0;
            r_wcnt <= '0;
          end else if (w_req) begin
            if (w_hit) begin
              r_hits <= r_hits + 32'd1;
              if (dmemWEN) r_dirty[w_idx][w_hway] <= 1'b1;
              for (int w = 0; w < WAYS; w++)
                if (AW'(w) == w_hway) r_age[w_idx][w] <= '0;
                else if (r_age[w_idx][w] < r_age[w_idx][w_hway])
                  r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
            end else begin
              r_vway <= w_vway;
              r_midx <= w_idx;
              r_mtag <= w_tag;
              r_wcnt <= '0;
            end
          end
        S_WB:
          if (!dwait) begin
            r_wcnt <= w_wnext;
            if (w_last) r_dirty[r_midx][r_vway] <= 1'b0;
          end
        S_FILL:
          if (!dwait) begin
            r_wcnt <= w_wnext;
            if (w_last) begin
              r_valid[r_midx][r_vway] <= 1'b1;
              r_dirty[r_midx][r_vway] <= 1'b0;
            end
          end
        S_FLUSH:
          if (w_sdirty) begin
            if (!dwait) begin
              r_wcnt <= w_wnext;
              if (w_last) begin
                r_dirty[w_sidx][w_sway] <= 1'b0;
                r_scan <= r_scan + 1'b1;
              end
            end
          end else r_scan <= r_scan + 1'b1;
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && !halt && w_hit && dmemWEN)
      r_data[w_idx][w_hway][w_woff] <= dmemstore;
    else if (r_state == S_FILL && !dwait) begin
      r_data[r_midx][r_vway][r_wcnt] <= dload;
      if (w_last) r_tag[r_midx][r_vway] <= r_mtag;
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Self-checking bench for dcache_nway: directed steps plus random traffic
// against a flat reference memory and a per-set recency list model.
module tb_dcache_nway;
  localparam int SETS = 8, WAYS = 2, WORDS = 2;

  logic CLK = 1'b0, RST;
  logic dmemREN, dmemWEN, halt, dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

  dcache_nway #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .CPUID(0)) dut (
    .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .dmemload(dmemload), .dhit(dhit),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait));

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int ws = 0, bcnt = 0;
  bit mem_init = 1'b0;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] wb_a[$], wb_d[$], rd_a[$];

  typedef struct { int tag; bit dirty; } line_t;
  line_t m_set[SETS][$];

  function automatic logic [31:0] pattern(input int i);
    pattern = (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 ^ (32'(i) * 32'h01010101));
  endfunction

  // Memory: ws wait cycles per transfer; completed transfers are logged.
  assign dwait = (dREN || dWEN) && (bcnt < ws);
  assign dload = mem[daddr[11:2]];
  always @(posedge CLK) begin
    if (RST) begin
      bcnt <= 0;
      if (mem_init) for (int i = 0; i < 1024; i++) mem[i] <= pattern(i);
    end else if (!(dREN || dWEN)) bcnt <= 0;
    else if (bcnt < ws) bcnt <= bcnt + 1;
    else begin
      bcnt <= 0;
      if (dWEN) begin
        wb_a.push_back(daddr);
        wb_d.push_back(dstore);
        if (daddr < 32'h1000) mem[daddr[11:2]] <= dstore;
      end else rd_a.push_back(daddr);
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) m_set[s].delete();
  endtask

  // One CPU access, started right after a falling edge; held until dhit.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] ld);
    int blk, idx, tg, pos, cyc, nwb0, nrd0, vtag;
    bit hit, full, vdirty, pw;
    logic [31:0] pa, ps;
    line_t l;
    blk = int'(a) / (4 * WORDS); idx = blk % SETS; tg = blk / SETS;
    pos = -1;
    for (int i = 0; i < m_set[idx].size(); i++) if (m_set[idx][i].tag == tg) pos = i;
    hit    = (pos >= 0);
    full   = (m_set[idx].size() == WAYS);
    vdirty = !hit && full && m_set[idx][WAYS-1].dirty;
    vtag   = full ? m_set[idx][WAYS-1].tag : 0;
    nwb0 = wb_a.size(); nrd0 = rd_a.size();
    dmemWEN = we; dmemREN = !we; dmemaddr = a; dmemstore = d;
    cyc = 0; pw = 1'b0; pa = '0; ps = '0;
    #1;
    while (!dhit && cyc < 400) begin
      if (pw && (dREN || dWEN)) begin
        chk("hold_daddr", daddr, pa);
        chk("hold_dstore", dstore, ps);
      end
      if (dREN || dWEN) chk("ren_wen_excl", 32'(dREN & dWEN), 32'd0);
      pw = dwait; pa = daddr; ps = dstore;
      @(negedge CLK); #1; cyc++;
    end
    chk("latency", cyc, hit ? 0 : 1 + WORDS * (ws + 1) * (vdirty ? 2 : 1));
    ld = dmemload;
    if (!we) chk("load", ld, ref_mem[a[11:2]]);
    @(negedge CLK);
    dmemREN = 1'b0; dmemWEN = 1'b0;
    chk("wb_count", wb_a.size() - nwb0, vdirty ? WORDS : 0);
    if (vdirty && wb_a.size() - nwb0 == WORDS)
      for (int i = 0; i < WORDS; i++) begin
        chk("wb_addr", wb_a[nwb0+i], 32'(((vtag * SETS + idx) * WORDS + i) * 4));
        chk("wb_data", wb_d[nwb0+i], ref_mem[(vtag * SETS + idx) * WORDS + i]);
      end
    chk("fill_count", rd_a.size() - nrd0, hit ? 0 : WORDS);
    if (!hit && rd_a.size() - nrd0 == WORDS)
      for (int i = 0; i < WORDS; i++)
        chk("fill_addr", rd_a[nrd0+i], 32'((blk * WORDS + i) * 4));
    if (hit) begin
      l = m_set[idx][pos];
      m_set[idx].delete(pos);
    end else begin
      if (full) void'(m_set[idx].pop_back());
      l.tag = tg; l.dirty = 1'b0;
    end
    l.dirty = l.dirty | we;
    m_set[idx].push_front(l);
    if (we) ref_mem[a[11:2]] = d;
  endtask

  initial begin
    logic [31:0] ld, a;
    int n0, r0, mism, cyc;
    RST = 1'b1; mem_init = 1'b1; halt = 1'b0;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_dhit", 32'(dhit), 0);   chk("rst_dREN", 32'(dREN), 0);
    chk("rst_dWEN", 32'(dWEN), 0);   chk("rst_flushed", 32'(flushed), 0);
    chk("rst_daddr", daddr, 0);      chk("rst_dstore", dstore, 0);
    chk("rst_dmemload", dmemload, 0);
    RST = 1'b0; mem_init = 1'b0;
    @(negedge CLK);

    // Cold read then repeat hit
    access(0, 32'h40, 0, ld);
    chk("cold_load", ld, 32'hDEADBEEF);
    access(0, 32'h40, 0, ld);
    chk("cold_rehit", ld, 32'hDEADBEEF);

    // Write hit, then two same-set misses evict the dirty block
    access(1, 32'h40, 32'h1234, ld);
    access(0, 32'h240, 0, ld);
    n0 = wb_a.size(); r0 = rd_a.size();
    access(0, 32'h440, 0, ld);
    if (wb_a.size() >= n0 + 2 && rd_a.size() > r0) begin
      chk("evict_a0", wb_a[n0], 32'h40);   chk("evict_d0", wb_d[n0], 32'h1234);
      chk("evict_a1", wb_a[n0+1], 32'h44); chk("evict_fill", rd_a[r0], 32'h440);
    end else chk("evict_transfers", wb_a.size() - n0, 2);

    // LRU: A, B, re-touch A, miss C evicts B; A still hits
    access(0, 32'h10, 0, ld);
    access(0, 32'h210, 0, ld);
    access(0, 32'h10, 0, ld);
    access(0, 32'h410, 0, ld);
    access(0, 32'h10, 0, ld);
    access(0, 32'h210, 0, ld);

    // Wait states
    ws = 3;
    access(0, 32'h850, 0, ld);
    access(1, 32'h854, 32'hA5A5_0001, ld);
    access(0, 32'h610, 0, ld);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      ws = $urandom_range(0, 2);
      a = 32'((((($urandom_range(0, 5) * SETS) + $urandom_range(0, SETS - 1)) * WORDS)
               + $urandom_range(0, WORDS - 1)) * 4);
      access(1'($urandom_range(0, 1)), a, $urandom, ld);
    end

    // Reset during the second fill transfer
    ws = 2;
    a = 32'(((20 * SETS + 3) * WORDS) * 4);
    r0 = rd_a.size();
    dmemREN = 1'b1; dmemaddr = a;
    cyc = 0;
    while (!(rd_a.size() > r0 && dREN) && cyc < 100) begin @(negedge CLK); cyc++; end
    chk("midfill_reached", 32'(cyc < 100), 1);
    #1 RST = 1'b1;
    #1;
    chk("midfill_dREN", 32'(dREN), 0);
    chk("midfill_dWEN", 32'(dWEN), 0);
    @(negedge CLK);
    RST = 1'b0; dmemREN = 1'b0;
    model_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    @(negedge CLK);
    access(0, a, 0, ld);

    // Dirty blocks in sets 0 and 7, five hits total, then halt
    ws = 0;
    access(1, 32'h0, 32'h1111_0000, ld);
    access(1, 32'h38, 32'h7777_0038, ld);
    access(0, 32'h4, 0, ld);
    access(0, 32'h3C, 0, ld);
    ws = 1;
    n0 = wb_a.size();
    halt = 1'b1;
    cyc = 0;
    while (!flushed && cyc < 200) begin @(negedge CLK); #1; cyc++; end
    chk("flush_done", 32'(flushed), 1);
    chk("flush_count", wb_a.size() - n0, 5);
    if (wb_a.size() - n0 == 5) begin
      chk("flush_a0", wb_a[n0],   32'h0);  chk("flush_d0", wb_d[n0],   32'h1111_0000);
      chk("flush_a1", wb_a[n0+1], 32'h4);  chk("flush_d1", wb_d[n0+1], ref_mem[1]);
      chk("flush_a2", wb_a[n0+2], 32'h38); chk("flush_d2", wb_d[n0+2], 32'h7777_0038);
      chk("flush_a3", wb_a[n0+3], 32'h3C); chk("flush_d3", wb_d[n0+3], ref_mem[15]);
      chk("hitcnt_addr", wb_a[n0+4], 32'h3100);
      chk("hitcnt_data", wb_d[n0+4], 32'd5);
    end
    halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      chk("done_flushed", 32'(flushed), 1);
      chk("done_dhit", 32'(dhit), 0);
    end
    dmemREN = 1'b0;
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
